fetch_predict_unit: RTL and testbench

Instruction-fetch stage of the RISC-V 5-stage pipeline, the producer side of the IF/ID boundary. It owns the program counter, drives the instruction-memory address, and presents `pc_F`, `pc4_F`, `instr_F` and `takenF` to the IF/ID register. Next-PC selection uses a direct-mapped branch target buffer (BTB) and 2-bit bimodal counters (BHT). Branch outcomes resolved in EX train both structures, and a direction mismatch redirects the PC and raises a flush request to the hazard unit.

---
 rtl/fetch_predict_unit.sv | 101 ++++++++++
 tb/tb_fetch_predict_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_predict_unit.sv
// Instruction-fetch stage: PC register, BTB + 2-bit bimodal BHT next-PC prediction,
// and EX-side branch resolution that trains the predictor and redirects on a wrong direction.
module fetch_predict_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IDX_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallF,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_F,
  output logic [31:0] pc4_F,
  output logic [31:0] instr_F,
  output logic        takenF,
  input  logic        resolve_valid_E,
  input  logic [31:0] resolve_pc_E,
  input  logic        resolve_taken_E,
  input  logic [31:0] resolve_target_E,
  input  logic        resolve_pred_E,
  output logic        mispredict_E
);

  localparam int unsigned Depth = 2 ** IDX_W;
  localparam int unsigned TagW  = 30 - IDX_W;

  logic [31:0]      pc_q, pc_d;
  logic             btb_valid_q  [Depth];
  logic [TagW-1:0]  btb_tag_q    [Depth];
  logic [31:0]      btb_target_q [Depth];
  logic [1:0]       bht_q        [Depth];

  logic [IDX_W-1:0] fetch_idx, res_idx;
  logic [TagW-1:0]  fetch_tag, res_tag;
  logic             btb_hit;
  logic [1:0]       bht_cur, bht_next;

  assign fetch_idx = pc_q[IDX_W+1:2];
  assign fetch_tag = pc_q[31:IDX_W+2];
  assign res_idx   = resolve_pc_E[IDX_W+1:2];
  assign res_tag   = resolve_pc_E[31:IDX_W+2];

  assign pc_F      = pc_q;
  assign pc4_F     = pc_q + 32'd4;
  assign imem_addr = pc_q;
  assign instr_F   = imem_rdata;

  // Lookup reads the registered arrays, so a same-cycle update is seen only next cycle.
  assign btb_hit      = btb_valid_q[fetch_idx] && (btb_tag_q[fetch_idx] == fetch_tag);
  assign takenF       = btb_hit && bht_q[fetch_idx][1];
  assign mispredict_E = resolve_valid_E && (resolve_taken_E != resolve_pred_E);

  always_comb begin
    pc_d = pc4_F;
    if (mispredict_E) begin
      pc_d = resolve_taken_E ? resolve_target_E : (resolve_pc_E + 32'd4);
    end else if (stallF) begin
      pc_d = pc_q;
    end else if (takenF) begin
      pc_d = btb_target_q[fetch_idx];
    end
  end

  always_comb begin
    bht_cur  = bht_q[res_idx];
    bht_next = bht_cur;
    if (resolve_taken_E) begin
      if (bht_cur != 2'b11) bht_next = bht_cur + 2'b01;
    end else begin
      if (bht_cur != 2'b00) bht_next = bht_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Training ignores stallF: the resolving instruction is already in EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
        bht_q[i]        <= 2'b01;
      end
    end else if (resolve_valid_E) begin
      bht_q[res_idx] <= bht_next;
      if (resolve_taken_E) begin
        btb_valid_q[res_idx]  <= 1'b1;
        btb_tag_q[res_idx]    <= res_tag;
        btb_target_q[res_idx] <= resolve_target_E;
      end
    end
  end

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Self-checking bench for fetch_predict_unit: directed scenarios followed by random
// stimulus, compared every cycle against a table-based predictor model.
module tb_fetch_predict_unit;

  localparam int          IDX_W  = 4;
  localparam int          NENT   = 1 << IDX_W;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stallF = 1'b0;
  logic [31:0] imem_addr, imem_rdata, pc_F, pc4_F, instr_F;
  logic        takenF, mispredict_E;
  logic        resolve_valid_E = 1'b0;
  logic [31:0] resolve_pc_E = '0;
  logic        resolve_taken_E = 1'b0;
  logic [31:0] resolve_target_E = '0;
  logic        resolve_pred_E = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: PC plus per-index BTB/BHT tables.
  logic [31:0] m_pc;
  bit          m_v   [NENT];
  logic [31:0] m_tag [NENT];
  logic [31:0] m_tgt [NENT];
  int          m_ctr [NENT];

  fetch_predict_unit #(
    .RESET_PC (RST_PC),
    .IDX_W    (IDX_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stallF           (stallF),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .pc_F             (pc_F),
    .pc4_F            (pc4_F),
    .instr_F          (instr_F),
    .takenF           (takenF),
    .resolve_valid_E  (resolve_valid_E),
    .resolve_pc_E     (resolve_pc_E),
    .resolve_taken_E  (resolve_taken_E),
    .resolve_target_E (resolve_target_E),
    .resolve_pred_E   (resolve_pred_E),
    .mispredict_E     (mispredict_E)
  );

  always #5 clk = ~clk;

  // Fake instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]};
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % NENT);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> (IDX_W + 2);
  endfunction

  function automatic bit m_pred();
    int i;
    i = idx_of(m_pc);
    return m_v[i] && (m_tag[i] == tag_of(m_pc)) && (m_ctr[i] >= 2);
  endfunction

  task automatic model_reset();
    m_pc = RST_PC;
    for (int i = 0; i < NENT; i++) begin
      m_v[i]   = 1'b0;
      m_tag[i] = '0;
      m_tgt[i] = '0;
      m_ctr[i] = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check settled outputs, advance the model, cross the edge.
  task automatic step(input bit st, input bit rv, input logic [31:0] rpc, input bit rt,
                      input logic [31:0] rtg, input bit rp);
    bit          pred, mis;
    int          i;
    logic [31:0] nxt;
    stallF           = st;
    resolve_valid_E  = rv;
    resolve_pc_E     = rpc;
    resolve_taken_E  = rt;
    resolve_target_E = rtg;
    resolve_pred_E   = rp;
    #2;
    pred = m_pred();
    mis  = rv && (rt != rp);
    chk("pc_F", pc_F, m_pc);
    chk("pc4_F", pc4_F, m_pc + 32'd4);
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_F", instr_F, mem_word(m_pc));
    chk("takenF", {31'b0, takenF}, {31'b0, pred});
    chk("mispredict_E", {31'b0, mispredict_E}, {31'b0, mis});
    if (mis)       nxt = rt ? rtg : rpc + 32'd4;
    else if (st)   nxt = m_pc;
    else if (pred) nxt = m_tgt[idx_of(m_pc)];
    else           nxt = m_pc + 32'd4;
    if (rv) begin
      i = idx_of(rpc);
      if (rt) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_v[i]   = 1'b1;
        m_tag[i] = tag_of(rpc);
        m_tgt[i] = rtg;
      end else begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
    end
    m_pc = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc_F, RST_PC);
    chk("reset_taken", {31'b0, takenF}, 32'h0);
    rst_n = 1'b1;

    // Sequential fetch and a 3-cycle stall at 0x8.
    idle();
    idle();
    chk("stall_start", pc_F, 32'h8);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("after_stall", pc_F, 32'h8);
    idle();
    chk("post_stall", pc_F, 32'hC);
    idle();

    // Train 0x10 -> 0x04 twice, each a redirect.
    step(1'b0, 1'b1, 32'h10, 1'b1, 32'h4, 1'b0);
    chk("train1_redirect", pc_F, 32'h4);
    step(1'b0, 1'b1, 32'h10, 1'b1, 32'h4, 1'b0);
    chk("train2_redirect", pc_F, 32'h4);
    idle();
    idle();
    idle();
    chk("trained_pc", pc_F, 32'h10);
    chk("trained_hit", {31'b0, takenF}, 32'h1);
    idle();
    chk("trained_target", pc_F, 32'h4);

    // Not-taken resolve drops counter 11 -> 10; prediction stays taken.
    step(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1);
    chk("nt_redirect", pc_F, 32'h14);
    step(1'b0, 1'b1, 32'hC, 1'b0, 32'h0, 1'b1);
    chk("refetch_pc", pc_F, 32'h10);
    chk("weak_taken_hit", {31'b0, takenF}, 32'h1);

    // Asynchronous reset mid-cycle with a redirect and training pending.
    stallF           = 1'b1;
    resolve_valid_E  = 1'b1;
    resolve_pc_E     = 32'h20;
    resolve_taken_E  = 1'b1;
    resolve_target_E = 32'h80;
    resolve_pred_E   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_pc", pc_F, RST_PC);
    chk("async_reset_taken", {31'b0, takenF}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_held_pc", pc_F, RST_PC);
    rst_n = 1'b1;

    // Redirect overrides stall.
    step(1'b1, 1'b1, 32'h20, 1'b1, 32'h80, 1'b0);
    chk("redirect_over_stall", pc_F, 32'h80);

    // Alias: index 0, tag 1 must not hit for PC 0x0; also PC wraps to 0.
    step(1'b0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
    chk("alias_pc", pc_F, 32'h0);
    chk("alias_taken", {31'b0, takenF}, 32'h0);
    step(1'b0, 1'b1, 32'h200, 1'b1, 32'hFFFF_FFFC, 1'b0);
    chk("wrap_top", pc_F, 32'hFFFF_FFFC);
    idle();
    chk("wrap_zero", pc_F, 32'h0);

    // Random traffic over a small PC window so entries hit, alias and retrain.
    for (int n = 0; n < 400; n++) begin
      step(($urandom % 4) == 0, ($urandom % 3) == 0, 32'($urandom_range(47, 0)) << 2,
           1'($urandom % 2), 32'($urandom_range(47, 0)) << 2, 1'($urandom % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
